c1_cell_bank: RTL and testbench

C1_CELL_BANK -- requirements
Module: c1_cell_bank

---
 rtl/c1_cell_bank_if.sv | 28 ++
 rtl/c1_cell_bank.sv | 119 +++++++++++
 tb/tb_c1_cell_bank.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/c1_cell_bank_if.sv
// Handshake/bus bundle for c1_cell_bank: configuration load, evaluation request and result.
// The master drives requests (testbench or upstream); the slave is the cell bank.
interface c1_cell_bank_if #(
  parameter int CH = 4,
  parameter int CW = 6
) ();
  logic          cfg_start;
  logic          cfg_valid;
  logic [CW-1:0] cfg_data;
  logic          cfg_ready;
  logic          in_valid;
  logic [CH-1:0] in_s0;
  logic [CH-1:0] in_s1;
  logic          in_ready;
  logic          out_valid;
  logic [CH-1:0] out_f;
  logic          configured;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_s0, in_s1,
    input  cfg_ready, in_ready, out_valid, out_f, configured
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_s0, in_s1,
    output cfg_ready, in_ready, out_valid, out_f, configured
  );
endinterface

// File: rtl/c1_cell_bank.sv
// Bank of CH independent C1 logic cells, each configured by a 6-bit word {A0,A1,SA,B0,B1,SB}.
// Optional macro C1_PIPE2_EN adds a second output register stage (latency 2 instead of 1).
module c1_cell_bank #(
  parameter int CH = 4,
  parameter int CW = 6
) (
  input logic           clk,
  input logic           rst_n,
  c1_cell_bank_if.slave bus
);

  localparam int CNT_W = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0] words [CH];
  logic          cfg_ready;
  logic          in_ready;
  logic          configured;
  logic          beat;
  logic          xfer;
  logic [CH-1:0] f_comb;

  function automatic logic c1_eval(input logic [CW-1:0] w, input logic s0, input logic s1);
    logic a_mux;
    logic b_mux;
    a_mux = w[3] ? w[4] : w[5];
    b_mux = w[0] ? w[1] : w[2];
    return (s0 | s1) ? b_mux : a_mux;
  endfunction

  assign beat = bus.cfg_valid && cfg_ready;
  // A transfer coinciding with cfg_start is dropped along with everything in flight.
  assign xfer = bus.in_valid && in_ready && !bus.cfg_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cfg_ready  <= 1'b0;
      in_ready   <= 1'b0;
      configured <= 1'b0;
      for (int i = 0; i < CH; i++) words[i] <= '0;
    end else if (bus.cfg_start) begin
      state      <= LOAD;
      cnt        <= '0;
      cfg_ready  <= 1'b1;
      in_ready   <= 1'b0;
      configured <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            words[cnt] <= bus.cfg_data;
            if (cnt == CNT_W'(CH - 1)) begin
              cnt        <= '0;
              state      <= RUN;
              cfg_ready  <= 1'b0;
              in_ready   <= 1'b1;
              configured <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    f_comb = '0;
    for (int i = 0; i < CH; i++) f_comb[i] = c1_eval(words[i], bus.in_s0[i], bus.in_s1[i]);
  end

  // Stage p0: first output register
  logic          vld_p0;
  logic [CH-1:0] f_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      f_p0   <= '0;
    end else begin
      vld_p0 <= xfer;
      if (xfer) f_p0 <= f_comb;
    end
  end

`ifdef C1_PIPE2_EN
  // Stage p1: optional second output register
  logic          vld_p1;
  logic [CH-1:0] f_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      f_p1   <= '0;
    end else begin
      vld_p1 <= vld_p0 && !bus.cfg_start;
      if (vld_p0 && !bus.cfg_start) f_p1 <= f_p0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_f     = f_p1;
`else
  assign bus.out_valid = vld_p0;
  assign bus.out_f     = f_p0;
`endif

  assign bus.cfg_ready  = cfg_ready;
  assign bus.in_ready   = in_ready;
  assign bus.configured = configured;

endmodule

// File: tb/tb_c1_cell_bank.sv
// Randomised and directed bench for c1_cell_bank against a behavioural model of the cell bank.
module tb_c1_cell_bank;
  localparam int CH = 4;
  localparam int CW = 6;
`ifdef C1_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic          v;
    logic [CH-1:0] f;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  c1_cell_bank_if #(.CH(CH), .CW(CW)) bus ();
  c1_cell_bank #(.CH(CH), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] m_words [CH];
  bit            m_load, m_run, m_conf;
  int            m_cnt;
  ent_t          pipe[$];
  logic [CH-1:0] last_f;
  int            nres = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] ref_eval(input logic [CH-1:0] s0, input logic [CH-1:0] s1);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) begin
      // word bits MSB..LSB: A0 A1 SA B0 B1 SB
      if (s0[i] || s1[i]) r[i] = m_words[i][0] ? m_words[i][1] : m_words[i][2];
      else                r[i] = m_words[i][3] ? m_words[i][4] : m_words[i][5];
    end
    return r;
  endfunction

  task automatic reset_model();
    ent_t e;
    for (int i = 0; i < CH; i++) m_words[i] = '0;
    m_load = 0; m_run = 0; m_conf = 0; m_cnt = 0;
    pipe.delete();
    e.v = 1'b0; e.f = '0;
    for (int i = 0; i < LAT - 1; i++) pipe.push_back(e);
    last_f = '0;
  endtask

  task automatic tick();
    ent_t e;
    logic xv;
    logic [CH-1:0] xf;
    xv = bus.in_valid && m_run && !bus.cfg_start;
    xf = ref_eval(bus.in_s0, bus.in_s1);
    if (bus.cfg_start) begin
      m_load = 1; m_run = 0; m_conf = 0; m_cnt = 0;
      foreach (pipe[k]) pipe[k].v = 1'b0;
    end else if (m_load && bus.cfg_valid) begin
      m_words[m_cnt] = bus.cfg_data;
      if (m_cnt == CH - 1) begin
        m_cnt = 0; m_load = 0; m_run = 1; m_conf = 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    e.v = xv; e.f = xf;
    pipe.push_back(e);
    while (pipe.size() >= LAT) begin
      e = pipe.pop_front();
      check("out_valid", bus.out_valid, e.v);
      if (e.v) begin
        check("out_f", bus.out_f, e.f);
        last_f = e.f;
        nres++;
      end else begin
        check("out_f_hold", bus.out_f, last_f);
      end
    end
    check("cfg_ready", bus.cfg_ready, m_load);
    check("in_ready", bus.in_ready, m_run);
    check("configured", bus.configured, m_conf);
  endtask

  task automatic load(input logic [CH*CW-1:0] ws, input bit gaps);
    int k;
    logic v;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    k = 0;
    while (k < CH) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.cfg_valid = v;
      bus.cfg_data  = ws[k*CW +: CW];
      tick();
      if (v) k++;
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic evals(input int n, input int pv);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = ($urandom_range(0, 99) < pv);
      bus.in_s0    = CH'($urandom);
      bus.in_s1    = CH'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (LAT) tick();
  endtask

  function automatic logic [CH*CW-1:0] rand_words();
    logic [CH*CW-1:0] ws;
    for (int i = 0; i < CH; i++) ws[i*CW +: CW] = CW'($urandom_range(0, 63));
    return ws;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [CH*CW-1:0] ws;
    int n0;

    rst_n = 1'b0;
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_s0 = '0; bus.in_s1 = '0;
    reset_model();
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_f", bus.out_f, '0);
    check("rst_cfg_ready", bus.cfg_ready, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_configured", bus.configured, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // evaluation requests while IDLE are ignored
    bus.in_valid = 1'b1; bus.in_s0 = 4'b1010; bus.in_s1 = 4'b0110;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (LAT) tick();

    // NOR in all channels
    load({CH{6'b111000}}, 1'b0);
    check("nor_configured", bus.configured, 1'b1);
    bus.in_valid = 1'b1; bus.in_s0 = 4'b0000; bus.in_s1 = 4'b0000;
    tick();
    bus.in_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("nor_valid", bus.out_valid, 1'b1);
    check("nor_f", bus.out_f, 4'b1111);
    repeat (2) tick();

    // OR in all channels
    load({CH{6'b000111}}, 1'b1);
    bus.in_valid = 1'b1; bus.in_s0 = 4'b0101; bus.in_s1 = 4'b0011;
    tick();
    bus.in_valid = 1'b0;
    repeat (LAT - 1) tick();
    check("or_valid", bus.out_valid, 1'b1);
    check("or_f", bus.out_f, 4'b0111);
    repeat (2) tick();

    // restart mid-load; the restarting cfg_start carries a beat that must be discarded
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data = 6'b101010; tick();
    bus.cfg_data = 6'b010101; tick();
    bus.cfg_start = 1'b1; bus.cfg_data = 6'b111111;
    tick();
    bus.cfg_start = 1'b0;
    ws = rand_words();
    for (int i = 0; i < CH; i++) begin
      check("restart_not_configured", bus.configured, 1'b0);
      bus.cfg_data = ws[i*CW +: CW];
      tick();
    end
    bus.cfg_valid = 1'b0;
    check("restart_configured", bus.configured, 1'b1);
    evals(6, 100);

    // back-to-back stream
    n0 = nres;
    evals(8, 100);
    check("b2b_count", nres - n0, 8);

    // randomised loads and sparse evaluation traffic
    for (int r = 0; r < 5; r++) begin
      load(rand_words(), 1'b1);
      evals(20, 60);
    end

    // cfg_start while results are in flight
    bus.in_valid = 1'b1; bus.in_s0 = CH'($urandom); bus.in_s1 = CH'($urandom);
    tick();
    bus.in_valid = 1'b0;
    load(rand_words(), 1'b0);
    evals(10, 80);

    // asynchronous reset with a result pending
    bus.in_valid = 1'b1; bus.in_s0 = 4'b1111; bus.in_s1 = 4'b0000;
    tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_f", bus.out_f, '0);
    check("arst_in_ready", bus.in_ready, 1'b0);
    check("arst_configured", bus.configured, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (LAT) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
